// File: rtl/wb_slave_mem.sv
// rtl/wb_slave_mem.sv - Wishbone classic single-access slave with word-organised data memory
//
// Wishbone classic slave backed by DEPTH_WORDS x 32-bit storage.
// Each request gets a fixed number of wait states before its response.
// Writes honour the byte-lane enables.
// A misaligned or out-of-window address terminates with wb_err_o instead of wb_ack_o.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   wb_cyc_i  bus cycle in progress; low during a wait state aborts the access
//   wb_stb_i  strobe; request valid when wb_cyc_i & wb_stb_i
//   wb_we_i   1 = write, 0 = read
//   wb_adr_i  byte address
//   wb_dat_i  write data
//   wb_sel_i  byte-lane enables, bit k covers bits [8k+7:8k]
//   wb_dat_o  read data, held between reads
//   wb_ack_o  one-cycle successful termination
//   wb_err_o  one-cycle error termination

module wb_slave_mem #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [IDX_W-1:0]  idx_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [31:0]       dat_q;
    logic              fault_q;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              req;
    logic [31:0]       off;
    logic [IDX_W-1:0]  idx_in;
    logic              fault_in;
    logic              commit;
    logic              c_fault;
    logic              c_we;
    logic [3:0]        c_sel;
    logic [31:0]       c_dat;
    logic [IDX_W-1:0]  c_idx;

    // Decode the live bus request. The commit source is the live bus when a
    // zero-wait request commits straight from IDLE. Otherwise it is the
    // request latched at sample time.
    always_comb begin
        req      = wb_cyc_i & wb_stb_i;
        off      = wb_adr_i - BASE_ADDR;
        idx_in   = off[IDX_W+1:2];
        fault_in = (wb_adr_i[1:0] != 2'b00)
                || (wb_adr_i < BASE_ADDR)
                || ((off >> 2) >= 32'(DEPTH_WORDS));

        if (state == S_IDLE) begin
            c_fault = fault_in;
            c_we    = wb_we_i;
            c_sel   = wb_sel_i;
            c_dat   = wb_dat_i;
            c_idx   = idx_in;
        end else begin
            c_fault = fault_q;
            c_we    = we_q;
            c_sel   = sel_q;
            c_dat   = dat_q;
            c_idx   = idx_q;
        end

        commit = 1'b0;
        if (state == S_IDLE) begin
            commit = req && (WAIT_STATES == 0);
        end else if (state == S_WAIT) begin
            // Dropping cyc on the commit edge counts as an abort.
            commit = wb_cyc_i && (wait_cnt == 4'd0);
        end
    end

    // The storage array is written here so that an asserted reset also
    // suppresses any commit. The reset branch leaves the array alone, so
    // memory contents survive reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= 4'd0;
            dat_q    <= 32'd0;
            fault_q  <= 1'b0;
            wb_dat_o <= 32'd0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req) begin
                        idx_q   <= idx_in;
                        we_q    <= wb_we_i;
                        sel_q   <= wb_sel_i;
                        dat_q   <= wb_dat_i;
                        fault_q <= fault_in;
                        if (WAIT_STATES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (!wb_cyc_i) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (commit) begin
                wb_err_o <= c_fault;
                wb_ack_o <= !c_fault;
                if (!c_fault) begin
                    if (c_we) begin
                        for (int k = 0; k < 4; k++) begin
                            if (c_sel[k]) begin
                                mem[c_idx][8*k +: 8] <= c_dat[8*k +: 8];
                            end
                        end
                    end else begin
                        wb_dat_o <= mem[c_idx];
                    end
                end
            end
        end
    end

endmodule

// File: doc/wb_slave_mem.md
Name: wb_slave_mem

Overview:
Wishbone classic single-access slave (responder) with word-organised synchronous data memory, serving the multicycle RISC-V core's data bus.
- Accepts read/write cycles from the core's bus master.
- Inserts a configurable number of wait states.
- Supports byte-lane writes.
- Signals decode and alignment faults through wb_err_o.
- Sits between the core's bus interface and data storage in the top-level system; the bench for the core uses it as the memory model.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words stored; power of two, minimum 4.
BASE_ADDR, 32'h0000_0000, byte address of word 0; multiple of 4.
WAIT_STATES, 1, idle cycles inserted between request sample and response; range 0..15.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset.
wb_cyc_i  in  1  bus cycle in progress.
wb_stb_i  in  1  strobe; request valid when wb_cyc_i and wb_stb_i are both high.
wb_we_i  in  1  1 = write, 0 = read.
wb_adr_i  in  32  byte address.
wb_dat_i  in  32  write data.
wb_sel_i  in  4  byte-lane enables; bit k selects bits [8k+7:8k].
wb_dat_o  out  32  read data, valid when wb_ack_o is high.
wb_ack_o  out  1  one-cycle successful termination.
wb_err_o  out  1  one-cycle error termination.

Behaviour:
- Reset (reset low, asynchronous): state IDLE, wait counter 0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0. Memory array is not cleared. Release is synchronous to the next clk edge by normal flop behaviour.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with wb_cyc_i & wb_stb_i, latch adr, we, sel and dat.
  - Compute fault = (adr[1:0] != 0) | (adr < BASE_ADDR) | (((adr - BASE_ADDR) >> 2) >= DEPTH_WORDS).
  - Go to WAIT with counter = WAIT_STATES-1 if WAIT_STATES > 0; otherwise commit and go to RESP.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, commit and go to RESP.
  - If wb_cyc_i is low at any WAIT edge, abort: return to IDLE with no commit and no ack/err.
  - wb_stb_i/wb_adr_i changes during WAIT are ignored; the latched values are used.
- Commit (same edge as entry to RESP):
  - Fault: no memory access; wb_dat_o unchanged; wb_err_o=1 next cycle.
  - Write: each selected lane of mem[index] gets the latched data byte; unselected lanes are unchanged. sel=0000 is a legal no-op write that still acks. wb_dat_o unchanged.
  - Read: wb_dat_o <= mem[index], full word regardless of sel.
  - Non-fault: wb_ack_o=1 next cycle.
- RESP: exactly one of ack/err is high for exactly one cycle. The next edge returns to IDLE unconditionally.
- Latency: request sampled at edge N; ack/err high during the cycle after edge N+WAIT_STATES, i.e. WAIT_STATES+1 cycles. Minimum back-to-back spacing is WAIT_STATES+2 cycles. A request still asserted in IDLE after the response is a new request; the master must drop stb at the ack edge.
- wb_dat_o holds its last read value between reads.
- Simultaneous events:
  - reset during WAIT/RESP: ack/err clear immediately and no commit occurs; the write is lost if reset arrives before the commit edge.
  - cyc drop on the commit edge counts as an abort: no commit.
- wb_ack_o and wb_err_o are never high together and are never high outside RESP.

Test Plan:
1. WAIT_STATES=1: write 0x0000102C to 0x64, sel=1111, then read 0x64 -> ack 2 cycles after each request sample, single-cycle ack, read wb_dat_o=0x0000102C, err never high.
2. After (1), write 0xAABBCCDD to 0x64 with sel=0010, then read -> 0x0000CC2C; write with sel=0000 -> ack, value unchanged.
3. Read 0x32 (misaligned), then write 0x100 (index 64, out of range) -> wb_err_o one cycle each, no ack, wb_dat_o and memory unchanged; a following read of 0x64 still returns 0x0000CC2C.
4. WAIT_STATES=3: write 0x12345678 to 0x08, drop wb_cyc_i after 2 wait cycles -> no ack/err, FSM in IDLE; read 0x08 returns the prior value (0 after power-up preload of 0).
5. Assert reset low mid-WAIT of a write to 0x0C -> ack/err and wb_dat_o go 0 immediately, no write; after release, a read of 0x0C acks normally.
6. WAIT_STATES=0: back-to-back reads of 0x00 and 0x04 -> ack in the cycle after each sample; second request accepted only from IDLE, with 2-cycle spacing.
